// File: rtl/irq_controller_multi.sv
// Machine-mode interrupt controller: fixed-priority (lowest index wins), per-line level/edge sensing, nesting FSM.
// Optional IRQ_ACK_EN macro adds irq_ack_o, a one-hot acknowledge of the line accepted this cycle.
module irq_controller_multi #(
    parameter int               N_IRQ      = 16,
    parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
    parameter logic [31:0]      CAUSE_BASE = 32'h1000_0010
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             exception_i,
    input  logic [N_IRQ-1:0] irq_req_i,
    input  logic [N_IRQ-1:0] irq_en_i,
    input  logic             mie_i,
    input  logic             mret_i,
    output logic             irq_o,
    output logic [31:0]      irq_cause_o,
    output logic             irq_ret_o,
    output logic [N_IRQ-1:0] irq_pending_o,
    output logic             irq_active_o
`ifdef IRQ_ACK_EN
    ,
    output logic [N_IRQ-1:0] irq_ack_o
`endif
);

    localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    localparam logic [2:0] S_BOOT    = 3'd0;
    localparam logic [2:0] S_IDLE    = 3'd1;
    localparam logic [2:0] S_IRQ     = 3'd2;
    localparam logic [2:0] S_IRQ_EXC = 3'd3;
    localparam logic [2:0] S_EXC     = 3'd4;

    logic [2:0]       r_state;
    logic [N_IRQ-1:0] r_edge_pend;
    logic [N_IRQ-1:0] r_req_q;
    logic [ID_W-1:0]  r_id_q;

    logic [2:0]       w_state_nxt;
    logic [N_IRQ-1:0] w_pend;
    logic [N_IRQ-1:0] w_masked;
    logic [N_IRQ-1:0] w_accept_oh;
    logic [N_IRQ-1:0] w_edge_set;
    logic [ID_W-1:0]  w_win_id;
    logic [ID_W-1:0]  w_cause_id;
    logic             w_take;

    // Level lines pass straight through; edge lines come from the sticky pend registers.
    assign w_pend     = (EDGE_MASK & r_edge_pend) | (~EDGE_MASK & irq_req_i);
    assign w_masked   = w_pend & irq_en_i;
    assign w_edge_set = EDGE_MASK & irq_req_i & ~r_req_q;

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_win_id = '0;
        for (int k = N_IRQ - 1; k >= 0; k--) begin
            if (w_masked[k]) w_win_id = ID_W'(k);
        end
    end

    assign w_take      = (r_state == S_IDLE) & ~exception_i & mie_i & (|w_masked);
    assign w_accept_oh = w_take ? ({{(N_IRQ-1){1'b0}}, 1'b1} << w_win_id) : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_BOOT:    w_state_nxt = S_IDLE;
            S_IDLE: begin
                if (exception_i)  w_state_nxt = S_EXC;
                else if (w_take)  w_state_nxt = S_IRQ;
            end
            S_IRQ: begin
                if (exception_i)  w_state_nxt = S_IRQ_EXC;
                else if (mret_i)  w_state_nxt = S_IDLE;
            end
            S_IRQ_EXC: if (mret_i) w_state_nxt = S_IRQ;
            S_EXC:     if (mret_i) w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_BOOT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_BOOT;
            r_edge_pend <= '0;
            r_req_q     <= '0;
            r_id_q      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_req_q     <= irq_req_i;
            // A new edge wins over an acceptance-clear landing in the same cycle.
            r_edge_pend <= EDGE_MASK & (w_edge_set | (r_edge_pend & ~w_accept_oh));
            if (w_take) r_id_q <= w_win_id;
        end
    end

    assign w_cause_id    = (r_state == S_IDLE) ? w_win_id : r_id_q;
    assign irq_cause_o   = CAUSE_BASE + 32'(w_cause_id);
    assign irq_o         = w_take;
    assign irq_ret_o     = mret_i & (r_state == S_IRQ) & ~exception_i;
    assign irq_pending_o = w_pend;
    assign irq_active_o  = (r_state == S_IRQ) | (r_state == S_IRQ_EXC);

`ifdef IRQ_ACK_EN
    assign irq_ack_o = w_accept_oh;
`endif

endmodule
